edge_detect_bank: RTL and testbench
===================================

# edge_detect_bank

Parametrised multi-channel edge detector with input synchronisation, programmable glitch filter, per-channel edge-mode selection and sticky event flags with a combined interrupt. It sits between asynchronous external pins (buttons, strobes, handshake lines) and the control logic or register file. It supersedes single-bit edge detection wherever more than one line, debouncing or interrupt reporting is needed.

## Interface
- CHANNELS, 8, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_BITS, 4, width of filter length and per-channel stability counter (≥1)

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- signal  in  CHANNELS  raw asynchronous inputs
- filter_len  in  FILTER_BITS  stability threshold F, shared by all channels; quasi-static
- mode  in  2*CHANNELS  per channel i bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clear  in  CHANNELS  per-channel clear of pending, sampled each cycle
- level  out  CHANNELS  filtered, synchronised level
- rise  out  CHANNELS  one-cycle pulse on filtered 0→1
- fall  out  CHANNELS  one-cycle pulse on filtered 1→0
- change  out  CHANNELS  rise | fall
- pending  out  CHANNELS  sticky flag, set by mode-enabled edge
- irq  out  1  OR of all pending bits

## Operation
- Per channel, fully independent; no cross-channel interaction except irq.
- Synchroniser: signal[i] shifts through SYNC_STAGES flops; last stage is s[i].
- Filter: counter cnt[i] (FILTER_BITS wide), registered level[i].
  - s == level: cnt ← 0.
  - s != level and cnt ≥ filter_len: level ← s, cnt ← 0.
  - s != level and cnt < filter_len: cnt ← cnt+1.
  - ≥ comparison: lowering filter_len mid-count never strands a channel.
  - F=0: level follows s with one cycle delay, no filtering.
  - Glitch on s shorter than F+1 consecutive cycles: no level change, no pulses.
- Edge pulses registered, same edge as level update: rise high for exactly the cycle in which level first reads 1 after 0; fall likewise; change = rise|fall. Never both rise and fall in one cycle.
- Pending: set when (rise & mode[0]) | (fall & mode[1]). clear[i] high clears. Set and clear in same cycle: set wins (pending stays 1). mode change does not affect already-set pending.
- irq = |pending, no added register stage.

## Timing
- Reset (async assert, released sync to clk by the surrounding design): sync chains, cnt, level, rise, fall, change, pending, irq all 0.
- Input held high through reset release yields a rise (and pending if mode enabled) after normal latency; this is required behaviour.
- Latency, input change stable before edge 1: s changes after edge SYNC_STAGES; level/rise/fall/change after edge SYNC_STAGES+1+F; pending after edge SYNC_STAGES+2+F; irq same cycle as pending.
- Minimum distinguishable pulse on signal: F+1 clk cycles after sync (plus metastability uncertainty of ±1 cycle).
- Throughput: one edge per channel per F+1 cycles max; back-to-back alternating edges when F=0.
- clear is level-sensitive: held high keeps pending at 0 except in cycles where a new enabled edge sets it.
- Reset asserted mid-count: everything returns to 0 immediately; no pulse emitted on release unless input then differs from 0.

## Test plan
- Reset values: rst high with signal=all ones → every output 0; release, F=0, SYNC_STAGES=2 → rise=all ones exactly once at edge 3, level=all ones from edge 3, pending all ones at edge 4 with mode=all 11.
- Glitch filter: F=3, channel 0 high 3 cycles after sync → no level change, no pulses; high 4 cycles → single rise, later single fall when low 4 cycles.
- Mode select: mode ch0=01, ch1=10, ch2=00, ch3=11; square wave on ch0–3 → pending set on ch0 by rise only, ch1 by fall only, ch2 never, ch3 both; rise/fall pulses on all four regardless.
- Clear vs set collision: pending[0]=1, clear[0] pulsed in same cycle as new enabled edge → pending[0] stays 1; clear alone next cycle → 0, irq 0 if no others pending.
- filter_len lowered 15→2 while cnt=10 → level updates next cycle, one pulse, cnt back to 0.
- Async reset mid-operation: assert rst between clk edges during count → outputs 0 before next clk edge; random multi-channel stimulus vs. reference model shows matching pulses and pending after release.

Source files
------------

// File: rtl/edge_detect_bank_if.sv
// Bundle of the edge_detect_bank data, control and status lines.
// The master modport drives the raw inputs and configuration and receives
// the filtered levels, edge pulses and event flags. The slave modport is the
// detector itself.
interface edge_detect_bank_if #(
    parameter int CHANNELS    = 8,
    parameter int FILTER_BITS = 4
);
    logic [CHANNELS-1:0]    i_signal;
    logic [FILTER_BITS-1:0] i_filter_len;
    logic [2*CHANNELS-1:0]  i_mode;
    logic [CHANNELS-1:0]    i_clear;
    logic [CHANNELS-1:0]    o_level;
    logic [CHANNELS-1:0]    o_rise;
    logic [CHANNELS-1:0]    o_fall;
    logic [CHANNELS-1:0]    o_change;
    logic [CHANNELS-1:0]    o_pending;
    logic                   o_irq;

    modport master (
        output i_signal, i_filter_len, i_mode, i_clear,
        input  o_level, o_rise, o_fall, o_change, o_pending, o_irq
    );

    modport slave (
        input  i_signal, i_filter_len, i_mode, i_clear,
        output o_level, o_rise, o_fall, o_change, o_pending, o_irq
    );
endinterface

// File: rtl/edge_detect_bank.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter with
// a shared stability threshold, registered rise/fall pulses, sticky pending
// flags gated by a per-channel edge mode, and an OR-combined interrupt.
// Channels are fully independent; only the interrupt combines them.
module edge_detect_bank #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    edge_detect_bank_if.slave bus
);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [CHANNELS-1:0][FILTER_BITS-1:0] r_cnt;
    logic [CHANNELS-1:0]                  r_level;
    logic [CHANNELS-1:0]                  r_rise;
    logic [CHANNELS-1:0]                  r_fall;
    logic [CHANNELS-1:0]                  r_pending;

    logic [CHANNELS-1:0]                  w_s;
    logic [CHANNELS-1:0]                  w_mode_rise;
    logic [CHANNELS-1:0]                  w_mode_fall;
    logic [CHANNELS-1:0]                  w_set;

    // Synchroniser chain: index 0 takes the raw pin, the last index is the
    // first value considered safe to use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_signal};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Glitch filter: the level only follows the synchronised input once it
    // has disagreed for filter_len+1 consecutive cycles. The >= test lets a
    // lowered threshold take effect on a counter that is already past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (w_s[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= bus.i_filter_len) begin
                    r_level[i] <= w_s[i];
                    r_cnt[i]   <= '0;
                    r_rise[i]  <= w_s[i];
                    r_fall[i]  <= ~w_s[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Split the packed two-bit mode fields into rise-enable and fall-enable.
    always_comb begin
        w_mode_rise = '0;
        w_mode_fall = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_mode_rise[i] = bus.i_mode[2*i];
            w_mode_fall[i] = bus.i_mode[2*i+1];
        end
    end

    assign w_set = (r_rise & w_mode_rise) | (r_fall & w_mode_fall);

    // Sticky event flags: a new enabled edge wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~bus.i_clear) | w_set;
        end
    end

    assign bus.o_level   = r_level;
    assign bus.o_rise    = r_rise;
    assign bus.o_fall    = r_fall;
    assign bus.o_change  = r_rise | r_fall;
    assign bus.o_pending = r_pending;
    assign bus.o_irq     = |r_pending;

endmodule

// File: tb/tb_edge_detect_bank.sv
// Bench for edge_detect_bank: directed scenarios followed by random
// multi-channel stimulus, all compared every cycle against a run-length
// reference model of the synchronise / filter / flag behaviour.
module tb_edge_detect_bank;
    localparam int CH = 8;
    localparam int SS = 2;
    localparam int FB = 4;

    logic clk;
    logic rst;

    edge_detect_bank_if #(.CHANNELS(CH), .FILTER_BITS(FB)) bus ();

    edge_detect_bank #(
        .CHANNELS   (CH),
        .SYNC_STAGES(SS),
        .FILTER_BITS(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [CH-1:0] hist[$];      // pin samples, newest first
    int            run_len[CH];  // consecutive samples disagreeing with level
    logic [CH-1:0] m_lvl, m_rise, m_fall, m_pend;
    int            rise0_cnt, fall0_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back('0);
        for (int i = 0; i < CH; i++) run_len[i] = 0;
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        m_pend = '0;
    endtask

    // One rising edge of the model, using the inputs present before the edge.
    task automatic model_edge();
        logic [CH-1:0] s;
        logic [CH-1:0] np;
        s = hist[SS-1];
        for (int i = 0; i < CH; i++) begin
            np[i] = (m_pend[i] && !bus.i_clear[i])
                 || (m_rise[i] && bus.i_mode[2*i])
                 || (m_fall[i] && bus.i_mode[2*i+1]);
        end
        m_pend = np;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) begin
            if (s[i] !== m_lvl[i]) begin
                run_len[i]++;
                if (run_len[i] > int'(bus.i_filter_len)) begin
                    m_lvl[i]   = s[i];
                    m_rise[i]  = s[i];
                    m_fall[i]  = ~s[i];
                    run_len[i] = 0;
                end
            end else begin
                run_len[i] = 0;
            end
        end
        hist.push_front(bus.i_signal);
        void'(hist.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("level",   64'(bus.o_level),   64'(m_lvl));
        chk("rise",    64'(bus.o_rise),    64'(m_rise));
        chk("fall",    64'(bus.o_fall),    64'(m_fall));
        chk("change",  64'(bus.o_change),  64'(m_rise | m_fall));
        chk("pending", 64'(bus.o_pending), 64'(m_pend));
        chk("irq",     64'(bus.o_irq),     64'(|m_pend));
        rise0_cnt += int'(bus.o_rise[0]);
        fall0_cnt += int'(bus.o_fall[0]);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   64'(bus.o_level),   64'd0);
        chk({tag, "_rise"},    64'(bus.o_rise),    64'd0);
        chk({tag, "_fall"},    64'(bus.o_fall),    64'd0);
        chk({tag, "_change"},  64'(bus.o_change),  64'd0);
        chk({tag, "_pending"}, 64'(bus.o_pending), 64'd0);
        chk({tag, "_irq"},     64'(bus.o_irq),     64'd0);
    endtask

    task automatic clear_all();
        bus.i_clear = '1;
        step();
        bus.i_clear = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got_fall;
        logic [CH-1:0] sig;

        // Reset with all pins high
        rst              = 1'b1;
        bus.i_signal     = '1;
        bus.i_mode       = '1;
        bus.i_filter_len = '0;
        bus.i_clear      = '0;
        model_reset();
        rise0_cnt = 0;
        fall0_cnt = 0;
        #23;
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("rst_e1_rise", 64'(bus.o_rise), 64'd0);
        step();
        chk("rst_e2_rise", 64'(bus.o_rise), 64'd0);
        step();
        chk("rst_e3_rise",  64'(bus.o_rise),  64'hFF);
        chk("rst_e3_level", 64'(bus.o_level), 64'hFF);
        step();
        chk("rst_e4_rise",    64'(bus.o_rise),    64'd0);
        chk("rst_e4_pending", 64'(bus.o_pending), 64'hFF);
        chk("rst_e4_irq",     64'(bus.o_irq),     64'd1);

        // Glitch filter, F=3, channel 0
        bus.i_signal     = '0;
        bus.i_mode       = 16'h0003;
        bus.i_filter_len = 4'd3;
        steps(10);
        clear_all();
        rise0_cnt = 0;
        fall0_cnt = 0;
        bus.i_signal[0] = 1'b1;
        steps(3);
        bus.i_signal[0] = 1'b0;
        steps(12);
        chk("glitch3_rise",  64'(rise0_cnt),       64'd0);
        chk("glitch3_fall",  64'(fall0_cnt),       64'd0);
        chk("glitch3_level", 64'(bus.o_level[0]),  64'd0);
        bus.i_signal[0] = 1'b1;
        steps(4);
        bus.i_signal[0] = 1'b0;
        steps(14);
        chk("pulse4_rise", 64'(rise0_cnt), 64'd1);
        chk("pulse4_fall", 64'(fall0_cnt), 64'd1);

        // Mode select: ch0 rise, ch1 fall, ch2 off, ch3 both
        bus.i_filter_len = '0;
        bus.i_mode       = 16'h00C9;
        steps(4);
        clear_all();
        bus.i_signal = 8'h0F;
        steps(5);
        chk("mode_after_rise", 64'(bus.o_pending & 8'h0F), 64'h9);
        clear_all();
        bus.i_signal = 8'h00;
        steps(5);
        chk("mode_after_fall", 64'(bus.o_pending & 8'h0F), 64'hA);

        // Clear colliding with a new enabled edge
        bus.i_mode = 16'h0003;
        clear_all();
        bus.i_signal[0] = 1'b1;
        steps(5);
        chk("coll_pend_set", 64'(bus.o_pending), 64'h01);
        bus.i_signal[0] = 1'b0;
        got_fall = 1'b0;
        for (int k = 0; k < 10 && !got_fall; k++) begin
            step();
            got_fall = bus.o_fall[0];
        end
        chk("coll_fall_seen", 64'(got_fall), 64'd1);
        bus.i_clear = 8'h01;
        step();
        chk("coll_set_wins", 64'(bus.o_pending[0]), 64'd1);
        step();
        chk("coll_clear_pend", 64'(bus.o_pending), 64'd0);
        chk("coll_clear_irq",  64'(bus.o_irq),     64'd0);
        bus.i_clear = '0;

        // Threshold lowered while a channel is mid-count
        bus.i_mode       = '0;
        bus.i_filter_len = 4'd15;
        steps(3);
        rise0_cnt = 0;
        bus.i_signal[0] = 1'b1;
        steps(12);
        chk("fl_hold_level", 64'(bus.o_level[0]), 64'd0);
        bus.i_filter_len = 4'd2;
        step();
        chk("fl_rise",  64'(bus.o_rise[0]),  64'd1);
        chk("fl_level", 64'(bus.o_level[0]), 64'd1);
        steps(3);
        chk("fl_once", 64'(rise0_cnt), 64'd1);
        bus.i_signal[0] = 1'b0;
        steps(SS + 2);
        chk("fl_cnt_restart_hold", 64'(bus.o_level[0]), 64'd1);
        step();
        chk("fl_cnt_restart_fall", 64'(bus.o_level[0]), 64'd0);

        // Async reset mid-count
        bus.i_filter_len = '0;
        bus.i_mode       = '1;
        bus.i_signal     = '1;
        steps(5);
        bus.i_filter_len = 4'd15;
        bus.i_signal     = '0;
        steps(6);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        bus.i_signal = 8'h3C;
        @(posedge clk);
        @(posedge clk);
        #4;
        rst = 1'b0;

        // Random multi-channel stimulus
        bus.i_filter_len = FB'($urandom_range(0, 3));
        bus.i_mode       = 16'($urandom);
        sig              = 8'h3C;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) sig = sig ^ CH'($urandom & $urandom);
            bus.i_signal = sig;
            bus.i_clear  = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            if ($urandom_range(0, 49) == 0) bus.i_mode = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
